// File: rtl/id_ex_hazard_stage.sv
// ----------------------------------------------------------------------------
// id_ex_hazard_stage
//
// ID/EX pipeline register for the MIPS_Processor datapath, with load-use
// hazard detection. The stage:
//   - registers the decoded control, operands and register indices for EX,
//   - raises stall_o (combinationally) so that PC and IF/ID hold when the
//     instruction in decode needs the result of a load that is now in EX,
//   - loads a bubble on a stall or a flush, and freezes while hold_i is high.
//     A flush that arrives while the stage is held is remembered and applied
//     on the first edge without hold.
//
// Optional feature macro: ID_EX_PERF_CNT_EN
//   When defined, adds saturating stall/flush event counters on the
//   stall_cnt_o and flush_cnt_o ports. When undefined, neither the counters
//   nor their ports exist.
// ----------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,

  // Decode-side inputs
  input  logic                      id_valid_i,
  input  logic [6:0]                id_ctrl_i,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_op_i,
  input  logic [DATA_WIDTH-1:0]     id_rd1_i,
  input  logic [DATA_WIDTH-1:0]     id_rd2_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic [DATA_WIDTH-1:0]     id_pc4_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
  input  logic                      id_uses_rt_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_wreg_i,

  // Pipeline control
  input  logic                      flush_i,
  input  logic                      hold_i,
  output logic                      stall_o,

  // Execute-side outputs
  output logic                      ex_valid_o,
  output logic [6:0]                ex_ctrl_o,
  output logic [ALU_OP_WIDTH-1:0]   ex_alu_op_o,
  output logic [DATA_WIDTH-1:0]     ex_rd1_o,
  output logic [DATA_WIDTH-1:0]     ex_rd2_o,
  output logic [DATA_WIDTH-1:0]     ex_imm_o,
  output logic [DATA_WIDTH-1:0]     ex_pc4_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_wreg_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
`endif
);

  // Control vector layout: {jal, shift, reg_write, mem_to_reg, mem_read,
  // mem_write, alu_src}. Only mem_read matters to hazard detection.
  localparam int CTRL_MEM_READ = 2;

  // What the stage does on the coming clock edge, in priority order.
  typedef enum logic [1:0] {
    ACT_HOLD,   // downstream cannot accept: freeze everything
    ACT_FLUSH,  // kill the decode slot (now or remembered from a hold)
    ACT_STALL,  // load-use: insert a bubble, IF/ID re-presents the consumer
    ACT_LOAD    // normal advance
  } action_e;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic                      valid_q,    valid_d;
  logic [6:0]                ctrl_q,     ctrl_d;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q,   alu_op_d;
  logic [DATA_WIDTH-1:0]     rd1_q,      rd1_d;
  logic [DATA_WIDTH-1:0]     rd2_q,      rd2_d;
  logic [DATA_WIDTH-1:0]     imm_q,      imm_d;
  logic [DATA_WIDTH-1:0]     pc4_q,      pc4_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q,       rs_d;
  logic [REG_ADDR_WIDTH-1:0] rt_q,       rt_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_q,     wreg_d;
  logic                      flush_pend_q, flush_pend_d;

  logic    load_use;
  action_e action;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------

  // Load-use: the load in EX writes a non-zero register that decode reads.
  // rt only counts when the decoded instruction actually reads it.
  always_comb begin
    load_use = valid_q
             & ctrl_q[CTRL_MEM_READ]
             & (wreg_q != '0)
             & id_valid_i
             & ((wreg_q == id_rs_i) | (id_uses_rt_i & (wreg_q == id_rt_i)));
  end

  // A flush (current or pending) outranks the stall: the consumer is being
  // killed anyway, so there is no reason to hold PC and IF/ID for it.
  assign stall_o = hold_i | (load_use & ~flush_i & ~flush_pend_q);

  // Select the edge action in priority order hold > flush > stall > load.
  always_comb begin
    if (hold_i) begin
      action = ACT_HOLD;
    end else if (flush_i | flush_pend_q) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_STALL;
    end else begin
      action = ACT_LOAD;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // Build the next contents of the stage from the selected action.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    alu_op_d     = alu_op_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    pc4_d        = pc4_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    wreg_d       = wreg_q;
    flush_pend_d = flush_pend_q;

    unique case (action)
      ACT_HOLD: begin
        // Contents stay put; a flush seen now is applied once hold drops.
        if (flush_i) flush_pend_d = 1'b1;
      end
      ACT_FLUSH, ACT_STALL: begin
        // Bubble: fully zeroed so it can never write registers or memory.
        valid_d  = 1'b0;
        ctrl_d   = '0;
        alu_op_d = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        imm_d    = '0;
        pc4_d    = '0;
        rs_d     = '0;
        rt_d     = '0;
        wreg_d   = '0;
        if (action == ACT_FLUSH) flush_pend_d = 1'b0;
      end
      ACT_LOAD: begin
        valid_d  = id_valid_i;
        // Control is squashed for an empty decode slot so that ctrl is
        // all-zero whenever valid is low.
        ctrl_d   = id_valid_i ? id_ctrl_i : '0;
        alu_op_d = id_alu_op_i;
        rd1_d    = id_rd1_i;
        rd2_d    = id_rd2_i;
        imm_d    = id_imm_i;
        pc4_d    = id_pc4_i;
        rs_d     = id_rs_i;
        rt_d     = id_rt_i;
        wreg_d   = id_wreg_i;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      alu_op_q     <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      wreg_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its neighbours, independent of statement order.
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      alu_op_q     <= alu_op_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc4_q        <= pc4_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      wreg_q       <= wreg_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign ex_valid_o  = valid_q;
  assign ex_ctrl_o   = ctrl_q;
  assign ex_alu_op_o = alu_op_q;
  assign ex_rd1_o    = rd1_q;
  assign ex_rd2_o    = rd2_q;
  assign ex_imm_o    = imm_q;
  assign ex_pc4_o    = pc4_q;
  assign ex_rs_o     = rs_q;
  assign ex_rt_o     = rt_q;
  assign ex_wreg_o   = wreg_q;

`ifdef ID_EX_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Count stall and flush edges, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((action == ACT_STALL) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if ((action == ACT_FLUSH) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//
// Directed scenarios plus randomized traffic for id_ex_hazard_stage, checked
// against a slot-level reference model. Inputs change 1 ns after a rising
// edge; stall_o is checked 2 ns after the edge and registered outputs 1 ns
// after the edge. Define ID_EX_PERF_CNT_EN to also check the counters.
// ----------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int OW  = 4;
  localparam int CW  = 16;

  localparam logic [6:0] CTRL_ADD  = 7'b0010000;  // reg_write
  localparam logic [6:0] CTRL_LW   = 7'b0011101;  // reg_write,mem_to_reg,mem_read,alu_src
  localparam logic [6:0] CTRL_ADDI = 7'b0010001;  // reg_write,alu_src

  logic clk = 1'b0;
  logic reset;
  logic          id_valid_i;
  logic [6:0]    id_ctrl_i;
  logic [OW-1:0] id_alu_op_i;
  logic [DW-1:0] id_rd1_i, id_rd2_i, id_imm_i, id_pc4_i;
  logic [AW-1:0] id_rs_i, id_rt_i, id_wreg_i;
  logic          id_uses_rt_i;
  logic          flush_i, hold_i;
  logic          stall_o;
  logic          ex_valid_o;
  logic [6:0]    ex_ctrl_o;
  logic [OW-1:0] ex_alu_op_o;
  logic [DW-1:0] ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc4_o;
  logic [AW-1:0] ex_rs_o, ex_rt_o, ex_wreg_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .ALU_OP_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i), .id_alu_op_i(id_alu_op_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i), .id_wreg_i(id_wreg_i),
    .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_wreg_o(ex_wreg_o)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  // --------------------------------------------------------------------------
  // Reference model: the EX slot as one record, plus the remembered flush
  // and the event counts.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic          valid;
    logic [6:0]    ctrl;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [AW-1:0] rs, rt, wreg;
  } slot_t;

  slot_t m_ex;
  bit    m_pend;
  int    m_scnt, m_fcnt;

  function automatic slot_t dut_slot();
    return {ex_valid_o, ex_ctrl_o, ex_alu_op_o, ex_rd1_o, ex_rd2_o, ex_imm_o,
            ex_pc4_o, ex_rs_o, ex_rt_o, ex_wreg_o};
  endfunction

  function automatic bit model_load_use();
    if (!(m_ex.valid && m_ex.ctrl[2] && m_ex.wreg != 0 && id_valid_i)) return 1'b0;
    return (m_ex.wreg == id_rs_i) || (id_uses_rt_i && m_ex.wreg == id_rt_i);
  endfunction

  function automatic bit model_stall();
    return hold_i || (model_load_use() && !flush_i && !m_pend);
  endfunction

  function automatic void model_reset();
    m_ex   = '0;
    m_pend = 1'b0;
    m_scnt = 0;
    m_fcnt = 0;
  endfunction

  // One clock edge of the model, evaluated on the inputs present at the edge.
  function automatic void model_edge();
    bit lu;
    lu = model_load_use();
    if (hold_i) begin
      if (flush_i) m_pend = 1'b1;
    end else if (flush_i || m_pend) begin
      m_ex   = '0;
      m_pend = 1'b0;
      if (m_fcnt < (1 << CW) - 1) m_fcnt++;
    end else if (lu) begin
      m_ex = '0;
      if (m_scnt < (1 << CW) - 1) m_scnt++;
    end else begin
      m_ex = {id_valid_i, id_valid_i ? id_ctrl_i : 7'd0, id_alu_op_i, id_rd1_i,
              id_rd2_i, id_imm_i, id_pc4_i, id_rs_i, id_rt_i, id_wreg_i};
    end
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (no comparisons here)
  // --------------------------------------------------------------------------
  task automatic idle_inputs();
    id_valid_i   = 1'b0;
    id_ctrl_i    = '0;
    id_alu_op_i  = '0;
    id_rd1_i     = '0;
    id_rd2_i     = '0;
    id_imm_i     = '0;
    id_pc4_i     = '0;
    id_rs_i      = '0;
    id_rt_i      = '0;
    id_uses_rt_i = 1'b0;
    id_wreg_i    = '0;
    flush_i      = 1'b0;
    hold_i       = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] ctrl, input int rs, input int rt,
                           input bit uses_rt, input int wreg, input int rd1,
                           input int rd2);
    id_valid_i   = 1'b1;
    id_ctrl_i    = ctrl;
    id_rs_i      = AW'(rs);
    id_rt_i      = AW'(rt);
    id_uses_rt_i = uses_rt;
    id_wreg_i    = AW'(wreg);
    id_rd1_i     = DW'(rd1);
    id_rd2_i     = DW'(rd2);
    id_alu_op_i  = OW'($urandom_range(0, 15));
    id_imm_i     = $urandom;
    id_pc4_i     = $urandom;
  endtask

  // Apply one rising edge to DUT and model; return 1 ns after the edge.
  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++;
    if (dut_slot() !== slot_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", dut_slot());
    end
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b want 0", stall_o);
    end
`ifdef ID_EX_PERF_CNT_EN
    tests_run++;
    if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
    end
`endif
  endtask

  task automatic test_pass_through();
    apply_reset();
    set_instr(CTRL_ADD, 1, 2, 1'b1, 3, 5, 7);
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass_stall: got %b want 0", stall_o);
    end
    #1; advance();
    tests_run++;
    if (ex_rd1_o !== 32'd5 || ex_rd2_o !== 32'd7 || ex_wreg_o !== 5'd3 ||
        ex_valid_o !== 1'b1 || ex_ctrl_o !== CTRL_ADD) begin
      tests_failed++;
      $display("FAIL pass_fields: got rd1=%0d rd2=%0d wreg=%0d v=%b ctrl=%b want 5 7 3 1 %b",
               ex_rd1_o, ex_rd2_o, ex_wreg_o, ex_valid_o, ex_ctrl_o, CTRL_ADD);
    end
    tests_run++;
    if (dut_slot() !== m_ex) begin
      tests_failed++;
      $display("FAIL pass_slot: got %h want %h", dut_slot(), m_ex);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_instr(CTRL_LW, 1, 9, 1'b0, 4, 100, 0);
    advance();
    set_instr(CTRL_ADD, 4, 2, 1'b1, 3, 11, 12);
    #1;
    tests_run++;
    if (stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL lu_stall_raise: got %b want 1", stall_o);
    end
    #1; advance();
    tests_run++;
    if (ex_valid_o !== 1'b0 || ex_ctrl_o !== 7'd0) begin
      tests_failed++;
      $display("FAIL lu_bubble: got v=%b ctrl=%b want 0 0", ex_valid_o, ex_ctrl_o);
    end
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_stall_one_cycle: got %b want 0", stall_o);
    end
    advance();
    tests_run++;
    if (ex_valid_o !== 1'b1 || ex_rs_o !== 5'd4 || ex_wreg_o !== 5'd3 || ex_rd1_o !== 32'd11) begin
      tests_failed++;
      $display("FAIL lu_replay: got v=%b rs=%0d wreg=%0d rd1=%0d want 1 4 3 11",
               ex_valid_o, ex_rs_o, ex_wreg_o, ex_rd1_o);
    end
  endtask

  task automatic test_zero_and_rt_unused();
    apply_reset();
    set_instr(CTRL_LW, 1, 0, 1'b0, 0, 0, 0);
    advance();
    set_instr(CTRL_ADD, 0, 0, 1'b1, 2, 0, 0);
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_reg_stall: got %b want 0", stall_o);
    end
    #1; advance();
    set_instr(CTRL_LW, 1, 5, 1'b0, 5, 0, 0);
    advance();
    set_instr(CTRL_ADDI, 1, 5, 1'b0, 5, 0, 0);
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rt_unused_stall: got %b want 0", stall_o);
    end
    id_uses_rt_i = 1'b1;
    #1;
    tests_run++;
    if (stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rt_used_stall: got %b want 1", stall_o);
    end
  endtask

  task automatic test_flush_vs_stall();
    apply_reset();
    set_instr(CTRL_LW, 1, 0, 1'b0, 7, 0, 0);
    advance();
    set_instr(CTRL_ADD, 7, 2, 1'b1, 3, 1, 2);
    flush_i = 1'b1;
    #1;
    tests_run++;
    if (stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: got %b want 0", stall_o);
    end
    #1; advance();
    flush_i = 1'b0;
    tests_run++;
    if (dut_slot() !== slot_t'(0)) begin
      tests_failed++;
      $display("FAIL flush_bubble: got %h want 0", dut_slot());
    end
  endtask

  task automatic test_hold_flush();
    apply_reset();
    set_instr(CTRL_ADD, 1, 2, 1'b1, 3, 5, 7);
    advance();
    set_instr(CTRL_ADDI, 8, 9, 1'b0, 10, 33, 44);
    hold_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      flush_i = (c == 2);
      #1;
      tests_run++;
      if (stall_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_stall_c%0d: got %b want 1", c, stall_o);
      end
      #1; advance();
      tests_run++;
      if (ex_valid_o !== 1'b1 || ex_wreg_o !== 5'd3 || ex_rd1_o !== 32'd5 || dut_slot() !== m_ex) begin
        tests_failed++;
        $display("FAIL hold_frozen_c%0d: got %h want %h", c, dut_slot(), m_ex);
      end
    end
    hold_i  = 1'b0;
    flush_i = 1'b0;
    advance();
    tests_run++;
    if (dut_slot() !== slot_t'(0)) begin
      tests_failed++;
      $display("FAIL hold_flush_bubble: got %h want 0", dut_slot());
    end
`ifdef ID_EX_PERF_CNT_EN
    tests_run++;
    if (flush_cnt_o !== 16'd1) begin
      tests_failed++;
      $display("FAIL hold_flush_cnt: got %0d want 1", flush_cnt_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_instr(CTRL_LW, 1, 0, 1'b0, 6, 0, 0);
    advance();
    for (int k = 0; k < 2; k++) begin
      // First consumer is another load into $6, second is an add.
      if (k == 0) set_instr(CTRL_LW, 6, 0, 1'b0, 6, 0, 0);
      else        set_instr(CTRL_ADD, 6, 6, 1'b1, 2, 0, 0);
      #1;
      tests_run++;
      if (stall_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_stall_k%0d: got %b want 1", k, stall_o);
      end
      #1; advance();
      tests_run++;
      if (stall_o !== 1'b0 || ex_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_bubble_k%0d: got stall=%b v=%b want 0 0", k, stall_o, ex_valid_o);
      end
      advance();
      tests_run++;
      if (ex_valid_o !== 1'b1 || ex_rs_o !== 5'd6) begin
        tests_failed++;
        $display("FAIL b2b_issue_k%0d: got v=%b rs=%0d want 1 6", k, ex_valid_o, ex_rs_o);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    set_instr(CTRL_LW, 1, 0, 1'b0, 4, 0, 0);
    advance();
    set_instr(CTRL_ADD, 4, 2, 1'b1, 3, 0, 0);
    #1;
    tests_run++;
    if (stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre_stall: got %b want 1", stall_o);
    end
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (dut_slot() !== slot_t'(0) || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: got %h stall=%b want 0 0", dut_slot(), stall_o);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      id_valid_i   = ($urandom_range(0, 7) != 0);
      id_ctrl_i    = 7'($urandom);
      if ($urandom_range(0, 1) == 1) id_ctrl_i[2] = 1'b1;
      id_alu_op_i  = OW'($urandom);
      id_rd1_i     = $urandom;
      id_rd2_i     = $urandom;
      id_imm_i     = $urandom;
      id_pc4_i     = $urandom;
      id_rs_i      = AW'($urandom_range(0, 3));
      id_rt_i      = AW'($urandom_range(0, 3));
      id_uses_rt_i = 1'($urandom);
      id_wreg_i    = AW'($urandom_range(0, 3));
      flush_i      = ($urandom_range(0, 7) == 0);
      hold_i       = ($urandom_range(0, 7) == 0);
      #1;
      tests_run++;
      if (stall_o !== model_stall()) begin
        tests_failed++;
        $display("FAIL rand_stall_n%0d: got %b want %b", n, stall_o, model_stall());
      end
      #1; advance();
      tests_run++;
      if (dut_slot() !== m_ex) begin
        tests_failed++;
        $display("FAIL rand_slot_n%0d: got %h want %h", n, dut_slot(), m_ex);
      end
`ifdef ID_EX_PERF_CNT_EN
      tests_run++;
      if (int'(stall_cnt_o) !== m_scnt || int'(flush_cnt_o) !== m_fcnt) begin
        tests_failed++;
        $display("FAIL rand_cnt_n%0d: got %0d/%0d want %0d/%0d",
                 n, stall_cnt_o, flush_cnt_o, m_scnt, m_fcnt);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_and_rt_unused();
    test_flush_vs_stall();
    test_hold_flush();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
